// File: rtl/accu_group.sv
// Group accumulator: sums up to GROUP beats (or fewer when last_a closes early) into one result beat.
// One cycle from the completing beat to valid_b; input stalls only while a result waits for ready_b.
module accu_group #(
  parameter int DATA_W = 8,
  parameter int GROUP  = 4,
  parameter int OUT_W  = 10,
  parameter int SAT    = 0,
  localparam int CNT_W = $clog2(GROUP + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_a,
  input  logic              last_a,
  output logic              ready_a,
  output logic              valid_b,
  input  logic              ready_b,
  output logic [OUT_W-1:0]  data_out,
  output logic [CNT_W-1:0]  count_b,
  output logic              ovf_b
);

  logic [OUT_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [OUT_W:0]   wide;
  logic [OUT_W-1:0] nxt;
  logic             ovf_nxt;
  logic             accept;
  logic             send;
  logic             done;

  assign ready_a = !valid_b || ready_b;
  assign accept  = valid_a && ready_a;
  assign send    = valid_b && ready_b;

  // Sticky ovf keeps a saturated sum pinned at all-ones until the group closes.
  assign wide    = {1'b0, sum} + (OUT_W+1)'(data_in);
  assign ovf_nxt = wide[OUT_W] || ovf;
  assign nxt     = ((SAT != 0) && ovf_nxt) ? {OUT_W{1'b1}} : wide[OUT_W-1:0];
  assign done    = accept && ((cnt == CNT_W'(GROUP - 1)) || last_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      valid_b  <= 1'b0;
      data_out <= '0;
      count_b  <= '0;
      ovf_b    <= 1'b0;
    end else if (done) begin
      // A send in the same cycle is covered: the new result replaces the old one without a bubble.
      data_out <= nxt;
      count_b  <= cnt + CNT_W'(1);
      ovf_b    <= ovf_nxt;
      valid_b  <= 1'b1;
      sum      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      if (send) begin
        valid_b <= 1'b0;
      end
      if (accept) begin
        sum <= nxt;
        cnt <= cnt + CNT_W'(1);
        ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_accu_group.sv
// Bench for accu_group: four parameterisations driven by shared stimulus, each checked every cycle
// against a group-level arithmetic model.
module tb_accu_group;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       valid_a = 1'b0;
  logic       last_a = 1'b0;
  logic       ready_b = 1'b1;

  logic       r0, r1, r2, r3;
  logic       v0, v1, v2, v3;
  logic [9:0] d0, d3;
  logic [8:0] d1, d2;
  logic [2:0] c0, c1, c2;
  logic [0:0] c3;
  logic       o0, o1, o2, o3;

  always #5 clk = ~clk;

  accu_group #(.DATA_W(8), .GROUP(4), .OUT_W(10), .SAT(0)) u_def (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_a(valid_a), .last_a(last_a),
    .ready_a(r0), .valid_b(v0), .ready_b(ready_b), .data_out(d0), .count_b(c0), .ovf_b(o0));
  accu_group #(.DATA_W(8), .GROUP(4), .OUT_W(9), .SAT(0)) u_wrap9 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_a(valid_a), .last_a(last_a),
    .ready_a(r1), .valid_b(v1), .ready_b(ready_b), .data_out(d1), .count_b(c1), .ovf_b(o1));
  accu_group #(.DATA_W(8), .GROUP(4), .OUT_W(9), .SAT(1)) u_sat9 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_a(valid_a), .last_a(last_a),
    .ready_a(r2), .valid_b(v2), .ready_b(ready_b), .data_out(d2), .count_b(c2), .ovf_b(o2));
  accu_group #(.DATA_W(8), .GROUP(1), .OUT_W(10), .SAT(0)) u_g1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_a(valid_a), .last_a(last_a),
    .ready_a(r3), .valid_b(v3), .ready_b(ready_b), .data_out(d3), .count_b(c3), .ovf_b(o3));

  int checks = 0;
  int errors = 0;

  int grp[4] = '{4, 4, 4, 1};
  int ow[4]  = '{10, 9, 9, 10};
  int sat[4] = '{0, 0, 1, 0};

  // Reference: plain integer total of the open group's beats; result formed at group close.
  int gsum[4];
  int gcnt[4];
  int ev[4];
  int ed[4];
  int ec[4];
  int eo[4];

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      gsum[i] = 0; gcnt[i] = 0; ev[i] = 0; ed[i] = 0; ec[i] = 0; eo[i] = 0;
    end
  endtask

  task automatic check_outs();
    int av[4];
    int ad[4];
    int ac[4];
    int ao[4];
    av = '{int'(v0), int'(v1), int'(v2), int'(v3)};
    ad = '{int'(d0), int'(d1), int'(d2), int'(d3)};
    ac = '{int'(c0), int'(c1), int'(c2), int'(c3)};
    ao = '{int'(o0), int'(o1), int'(o2), int'(o3)};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid_b[%0d]", i), av[i], ev[i]);
      if (ev[i] != 0) begin
        chk($sformatf("data_out[%0d]", i), ad[i], ed[i]);
        chk($sformatf("count_b[%0d]", i), ac[i], ec[i]);
        chk($sformatf("ovf_b[%0d]", i), ao[i], eo[i]);
      end
    end
  endtask

  task automatic check_ready();
    int ar[4];
    ar = '{int'(r0), int'(r1), int'(r2), int'(r3)};
    for (int i = 0; i < 4; i++)
      chk($sformatf("ready_a[%0d]", i), ar[i], (ev[i] == 0 || ready_b) ? 1 : 0);
  endtask

  // One clock: check registered outputs, drive inputs, check ready_a, advance the model.
  task automatic step(input bit v, input int d, input bit l, input bit rb);
    int maxv;
    bit acc;
    @(negedge clk);
    check_outs();
    valid_a = v; data_in = 8'(d); last_a = l; ready_b = rb;
    #1;
    check_ready();
    for (int i = 0; i < 4; i++) begin
      acc = v && (ev[i] == 0 || rb);
      if (acc) begin
        gsum[i] += d;
        gcnt[i] += 1;
      end
      if (acc && (gcnt[i] == grp[i] || l)) begin
        maxv  = (1 << ow[i]) - 1;
        eo[i] = (gsum[i] > maxv) ? 1 : 0;
        if (sat[i] != 0) ed[i] = (gsum[i] > maxv) ? maxv : gsum[i];
        else             ed[i] = gsum[i] % (maxv + 1);
        ec[i] = gcnt[i];
        ev[i] = 1;
        gsum[i] = 0;
        gcnt[i] = 0;
      end else if (ev[i] != 0 && rb) begin
        ev[i] = 0;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_a = 1'b0; ready_b = 1'b1; last_a = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs();
    check_ready();
    @(negedge clk);
    check_outs();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_outs();
    check_ready();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1,2,3,4 then idle: single result, valid for one cycle
    for (int k = 1; k <= 4; k++) step(1, k, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // 8 x 255 back-to-back: wrap/saturate at OUT_W=9, clean 1020 at OUT_W=10
    for (int k = 0; k < 8; k++) step(1, 255, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 1);
    step(0, 0, 0, 1);

    // early close with last_a, then a full group
    step(1, 5, 0, 1);
    step(1, 7, 1, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 1);
    step(0, 0, 0, 1);

    // held result: three stalled cycles, then send and accept together
    for (int k = 1; k <= 4; k++) step(1, k, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 50, 0, 0);
    step(1, 50, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 6, 0, 1);
    step(0, 0, 0, 1);

    // reset mid-group, then a clean group
    step(1, 9, 0, 1);
    step(1, 9, 0, 1);
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 1, 0, 1);
    step(0, 0, 0, 1);

    // reset while a result is held
    for (int k = 0; k < 4; k++) step(1, 2, 0, 0);
    step(0, 0, 0, 0);
    do_reset();

    // single-beat groups
    step(1, 3, 0, 1);
    step(1, 200, 0, 1);
    step(0, 0, 0, 1);

    // random traffic with backpressure, early closes and large beats
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) != 0) ? 255 - int'($urandom_range(0, 15)) : int'($urandom_range(0, 255)),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) != 0);
    end
    step(0, 0, 0, 1);

    @(negedge clk);
    check_outs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
